cp0_exc_responder: RTL and testbench

- Coprocessor-0 block for the 5-stage MIPS pipeline.
- Consumes exception/interrupt information carried into the M stage (M_pc, M_ExcCode, M_BD), decides whether to take a trap, and drives the single-cycle flush request Req back to all pipeline registers.
- Holds SR, Cause, EPC and PRId; services mfc0/mtc0/eret issued from the M stage.

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_timer.sv | 36 +++
 rtl/cp0_exc_responder.sv | 132 +++++++++++++
 tb/tb_cp0_exc_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, bit positions, exception codes and defaults
package cp0_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_SR      = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;

  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT       = 32'h2024_1105;

  // A delay-slot instruction restarts at its branch, one word earlier; EPC is word aligned.
  function automatic logic [31:0] trap_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] v;
    v = bd ? (pc - 32'd4) : pc;
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with sticky pending bit, built only under CP0_TIMER_EN
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  // Count free-runs unless written; a Compare write clears pending ahead of a match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      if (we && (addr == CP0_REG_COUNT)) begin
        count <= wdata;
      end else begin
        count <= count + 32'd1;
      end
      if (we && (addr == CP0_REG_COMPARE)) begin
        compare <= wdata;
        pending <= 1'b0;
      end else if (count == compare) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_responder.sv
// rtl/cp0_exc_responder.sv - CP0 trap decision, SR/Cause/EPC/PRId, mfc0/mtc0/eret; timer under CP0_TIMER_EN
module cp0_exc_responder
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = PRID_DEFAULT,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_pc,
  input  logic [4:0]  M_ExcCode,
  input  logic        M_BD,
  input  logic [5:0]  HWInt,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_en,
  output logic [31:0] cp0_rdata,
  output logic [31:0] EPC_out,
  output logic        Req,
  output logic [31:0] handler_pc
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip_hw;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic [5:0]  ip;
  logic        int_req;
  logic        exc_req;
  logic        mtc0_en;
  logic        timer_pend;
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic [31:0] sr_img;
  logic [31:0] cause_img;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we      (mtc0_en),
    .addr    (cp0_addr),
    .wdata   (cp0_wdata),
    .count   (count_val),
    .compare (compare_val),
    .pending (timer_pend)
  );
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign timer_pend  = 1'b0;
`endif

  assign ip      = {ip_hw[5] | timer_pend, ip_hw[4:0]};
  assign int_req = (|(ip & im)) & ie & ~exl;
  assign exc_req = (M_ExcCode != 5'd0) & ~exl;
  // Reset gates Req so a pending exception code cannot flush while the core is held.
  assign Req     = reset & (int_req | exc_req);
  // Trap beats eret, eret beats mtc0.
  assign mtc0_en = cp0_we & ~Req & ~eret_en;

  assign EPC_out    = epc;
  assign handler_pc = HANDLER_PC;

  // Cause.IP samples the interrupt lines every cycle and is never software-written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ip_hw <= '0;
    end else begin
      ip_hw <= HWInt;
    end
  end

  // Architectural state: trap entry, eret return, or mtc0, in that priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else if (Req) begin
      exl      <= 1'b1;
      exc_code <= int_req ? EXC_INT : M_ExcCode;
      bd       <= M_BD;
      epc      <= trap_epc(M_pc, M_BD);
    end else if (eret_en) begin
      exl <= 1'b0;
    end else if (mtc0_en) begin
      case (cp0_addr)
        CP0_REG_SR: begin
          im  <= cp0_wdata[SR_IM_MSB:SR_IM_LSB];
          exl <= cp0_wdata[SR_EXL_BIT];
          ie  <= cp0_wdata[SR_IE_BIT];
        end
        CP0_REG_EPC: epc <= cp0_wdata;
        default: ;
      endcase
    end
  end

  // Read images and mfc0 mux; unimplemented fields and registers read as zero.
  always_comb begin
    sr_img = '0;
    sr_img[SR_IM_MSB:SR_IM_LSB] = im;
    sr_img[SR_EXL_BIT]          = exl;
    sr_img[SR_IE_BIT]           = ie;

    cause_img = '0;
    cause_img[CAUSE_BD_BIT]                = bd;
    cause_img[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
    cause_img[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code;

    cp0_rdata = '0;
    case (cp0_addr)
      CP0_REG_COUNT:   cp0_rdata = count_val;
      CP0_REG_COMPARE: cp0_rdata = compare_val;
      CP0_REG_SR:      cp0_rdata = sr_img;
      CP0_REG_CAUSE:   cp0_rdata = cause_img;
      CP0_REG_EPC:     cp0_rdata = epc;
      CP0_REG_PRID:    cp0_rdata = PRID_VAL;
      default:         cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_responder.sv
// tb/tb_cp0_exc_responder.sv - self-checking bench for cp0_exc_responder; timer checks when CP0_TIMER_EN is defined
module tb_cp0_exc_responder;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif
  localparam logic [31:0] PRID  = 32'h2024_1105;
  localparam logic [31:0] HPC   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_pc;
  logic [4:0]  M_ExcCode;
  logic        M_BD;
  logic [5:0]  HWInt;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret_en;
  logic [31:0] cp0_rdata;
  logic [31:0] EPC_out;
  logic        Req;
  logic [31:0] handler_pc;

  cp0_exc_responder dut (
    .clk        (clk),
    .reset      (reset),
    .M_pc       (M_pc),
    .M_ExcCode  (M_ExcCode),
    .M_BD       (M_BD),
    .HWInt      (HWInt),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .eret_en    (eret_en),
    .cp0_rdata  (cp0_rdata),
    .EPC_out    (EPC_out),
    .Req        (Req),
    .handler_pc (handler_pc)
  );

  always #5 clk = ~clk;

  // reference model: architectural state as the programmer sees it
  logic [5:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_tpend;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_count, m_compare;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] obs_rdata;
  logic        obs_req;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_tpend = 0;
    m_ip = '0; m_exc = '0; m_epc = '0; m_count = '0; m_compare = '0;
  endtask

  function automatic logic [5:0] ip_eff();
    return m_ip | ((TIMER_ON && m_tpend) ? 6'b100000 : 6'b000000);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return TIMER_ON ? m_count : 32'd0;
      5'd11:   return TIMER_ON ? m_compare : 32'd0;
      5'd12:   return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) + (32'(ip_eff()) << 10) + (32'(m_exc) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One pipeline cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic cycle(input logic we, input logic [4:0] a, input logic [31:0] wd, input logic er,
                       input logic [4:0] ec, input logic bd, input logic [31:0] pc, input logic [5:0] hw);
    logic e_int, e_req, hit, wr;
    cp0_we = we; cp0_addr = a; cp0_wdata = wd; eret_en = er;
    M_ExcCode = ec; M_BD = bd; M_pc = pc; HWInt = hw;
    #4;
    e_int = ((ip_eff() & m_im) != 0) && m_ie && !m_exl;
    e_req = e_int || ((ec != 0) && !m_exl);
    obs_req = Req;
    obs_rdata = cp0_rdata;
    check_eq("req", Req, e_req);
    check_eq("rdata", cp0_rdata, model_read(a));
    check_eq("epc_out", EPC_out, m_epc);
    check_eq("handler_pc", handler_pc, HPC);
    @(posedge clk);
    hit = (m_count == m_compare);
    wr  = we && !e_req && !er;
    if (e_req) begin
      m_exl = 1;
      m_exc = e_int ? 5'd0 : ec;
      m_bd  = bd;
      m_epc = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    end else if (er) begin
      m_exl = 0;
    end else if (wr) begin
      if (a == 5'd12) begin
        m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
      end else if (a == 5'd14) begin
        m_epc = wd;
      end
    end
    if (TIMER_ON) begin
      if (wr && a == 5'd11) begin
        m_compare = wd; m_tpend = 0;
      end else if (hit) begin
        m_tpend = 1;
      end
      m_count = (wr && a == 5'd9) ? wd : m_count + 32'd1;
    end
    m_ip = hw;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, er, bd;
    logic [4:0]  a, ec;
    logic [31:0] wd, pc;
    logic [5:0]  hw;
    int          n;
    bit          done;

    reset = 0; M_pc = 0; M_ExcCode = 5'd12; M_BD = 0; HWInt = 0;
    cp0_we = 0; cp0_addr = 5'd12; cp0_wdata = 0; eret_en = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset_req", Req, 0);
    check_eq("reset_epc", EPC_out, 0);
    reset = 1;

    // reset image
    cycle(0, 12, 0, 0, 0, 0, 0, 0); check_eq("rst_sr", obs_rdata, 0);
    cycle(0, 13, 0, 0, 0, 0, 0, 0); check_eq("rst_cause", obs_rdata, 0);
    cycle(0, 14, 0, 0, 0, 0, 0, 0); check_eq("rst_epc", obs_rdata, 0);
    cycle(0, 15, 0, 0, 0, 0, 0, 0); check_eq("rst_prid", obs_rdata, PRID);
    check_eq("rst_req", obs_req, 0);

    // interrupt on HWInt[0]
    cycle(1, 12, 32'h0000_0401, 0, 0, 0, 32'h3000, 0);
    cycle(0, 14, 0, 0, 0, 0, 32'h3010, 6'b000001);
    cycle(0, 14, 0, 0, 0, 0, 32'h3010, 6'b000001); check_eq("int_req", obs_req, 1);
    cycle(0, 14, 0, 0, 0, 0, 32'h3014, 6'b000001); check_eq("int_epc", obs_rdata, 32'h3010);
    check_eq("int_req_masked", obs_req, 0);
    cycle(0, 13, 0, 0, 0, 0, 32'h3014, 6'b000001); check_eq("int_cause", obs_rdata, 32'h0000_0400);
    cycle(0, 12, 0, 0, 0, 0, 32'h3014, 6'b000001); check_eq("int_sr_exl", obs_rdata, 32'h0000_0403);
    cycle(0, 12, 0, 0, 0, 0, 32'h3014, 0);
    cycle(0, 12, 0, 1, 0, 0, 32'h3018, 0);

    // overflow in a delay slot
    cycle(0, 13, 0, 0, 5'd12, 1, 32'h3024, 0); check_eq("ov_req", obs_req, 1);
    cycle(0, 14, 0, 0, 0, 0, 32'h3028, 0); check_eq("ov_epc", obs_rdata, 32'h3020);
    cycle(0, 13, 0, 0, 0, 0, 32'h3028, 0); check_eq("ov_cause", obs_rdata, 32'h8000_0030);

    // EXL masks new traps; pending interrupt fires right after eret
    cycle(0, 12, 0, 0, 5'd10, 0, 32'h3030, 6'b000001); check_eq("nested_exc", obs_req, 0);
    cycle(0, 12, 0, 0, 0, 0, 32'h3034, 6'b000001); check_eq("masked_int", obs_req, 0);
    cycle(0, 12, 0, 1, 5'd10, 0, 32'h3038, 6'b000001); check_eq("eret_exc_masked", obs_req, 0);
    cycle(1, 14, 32'h5000, 0, 0, 0, 32'h3100, 6'b000001); check_eq("int_after_eret", obs_req, 1);
    cycle(0, 14, 0, 0, 0, 0, 32'h3104, 6'b000001); check_eq("epc_not_mtc0", obs_rdata, 32'h3100);

    // asynchronous reset in the middle of a trap
    cycle(0, 12, 0, 0, 0, 0, 32'h3108, 0); check_eq("pre_rst_exl", obs_rdata[1], 1);
    M_ExcCode = 5'd4; cp0_addr = 5'd12;
    #2 reset = 0;
    #1;
    check_eq("async_rst_req", Req, 0);
    check_eq("async_rst_sr", cp0_rdata, 0);
    check_eq("async_rst_epc", EPC_out, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1;

`ifdef CP0_TIMER_EN
    cycle(1, 11, 32'd5, 0, 0, 0, 32'h4000, 0);
    cycle(1, 12, 32'h0000_8001, 0, 0, 0, 32'h4004, 0);
    cycle(1, 9, 32'd0, 0, 0, 0, 32'h4008, 0);
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(0, 13, 0, 0, 0, 0, 32'h4010, 0);
      if (obs_req) done = 1; else n++;
    end
    check_eq("timer_latency", n, 6);
    cycle(1, 11, 32'd100, 0, 0, 0, 32'h4180, 0);
    cycle(0, 13, 0, 0, 0, 0, 32'h4184, 0); check_eq("timer_ip_clr", obs_rdata[15], 0);
    cycle(0, 13, 0, 1, 0, 0, 32'h4188, 0);
    cycle(0, 13, 0, 0, 0, 0, 32'h4190, 0); check_eq("timer_req_drop", obs_req, 0);
`endif

    // randomized traffic against the model
    hw = 0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 5'd9;
        1:       a = 5'd11;
        2, 3:    a = 5'd12;
        4:       a = 5'd13;
        5:       a = 5'd14;
        6:       a = 5'd15;
        default: a = 5'($urandom);
      endcase
      we = ($urandom_range(0, 3) == 0);
      wd = (a == 5'd9 || a == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
      er = ($urandom_range(0, 9) == 0);
      ec = 5'd0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0:       ec = 5'd4;
          1:       ec = 5'd5;
          2:       ec = 5'd8;
          3:       ec = 5'd10;
          4:       ec = 5'd12;
          default: ec = 5'($urandom_range(1, 31));
        endcase
      end
      bd = 1'($urandom);
      pc = $urandom;
      if ($urandom_range(0, 5) == 0) hw = 6'($urandom);
      cycle(we, a, wd, er, ec, bd, pc, hw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
